spdif_sample_pairer: RTL and testbench

SPDIF_SAMPLE_PAIRER -- requirements
Module: spdif_sample_pairer

---
 rtl/spdif_pkg.sv | 31 +++
 rtl/spdif_pair_fifo.sv | 73 +++++++
 rtl/spdif_sample_pairer.sv | 108 ++++++++++
 tb/tb_spdif_sample_pairer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared definitions for the S/PDIF sample pairer: sample widths, channel
// encodings, the hold-state type and pair packing helpers.
package spdif_pkg;

  localparam int SAMPLE_W = 24;
  localparam int PAIR_W   = 2 * SAMPLE_W;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_LEFT  = 1'b1
  } hold_state_t;

  function automatic logic [PAIR_W-1:0] pack_pair(
    input logic [SAMPLE_W-1:0] left,
    input logic [SAMPLE_W-1:0] right
  );
    return {left, right};
  endfunction

  function automatic logic [SAMPLE_W-1:0] pair_left(input logic [PAIR_W-1:0] pair);
    return pair[PAIR_W-1:SAMPLE_W];
  endfunction

  function automatic logic [SAMPLE_W-1:0] pair_right(input logic [PAIR_W-1:0] pair);
    return pair[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/spdif_pair_fifo.sv
// First-word-fall-through FIFO of stereo pairs. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise o_drop flags it.
module spdif_pair_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [PAIR_W-1:0]     i_wdata,
  input  logic                  i_pop,
  output logic [PAIR_W-1:0]     o_rdata,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_empty,
  output logic                  o_drop
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [PAIR_W-1:0]     r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_level == {(DEPTH_LOG2 + 1){1'b0}});
  assign w_full  = (r_level == LVL_FULL);
  assign w_pop   = i_pop & ~w_empty;
  // When full, the slot being written is the head being popped this cycle.
  assign w_wr    = i_push & (~w_full | w_pop);

  assign o_drop  = i_push & ~w_wr;
  assign o_level = r_level;
  assign o_empty = w_empty;
  assign o_rdata = w_empty ? {PAIR_W{1'b0}} : r_mem[r_rd_ptr];

  // Pair storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr <= {DEPTH_LOG2{1'b0}};
      r_level  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spdif_sample_pairer.sv
// Pairs left/right S/PDIF samples into stereo words and queues them in a
// FWFT FIFO; flags orphaned samples and pairs dropped on overflow.
module spdif_sample_pairer
  import spdif_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SAMPLE_W-1:0]   data_i,
  input  logic                  ack_i,
  input  logic                  lrck_i,
  input  logic                  locked_i,
  output logic [SAMPLE_W-1:0]   left_o,
  output logic [SAMPLE_W-1:0]   right_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  pair_err_o,
  output logic                  ovf_o
);

  hold_state_t          r_hold_state;
  hold_state_t          w_hold_next;
  logic [SAMPLE_W-1:0]  r_hold_data;
  logic [SAMPLE_W-1:0]  w_hold_data_next;
  logic                 r_pair_err;
  logic                 r_ovf;

  logic                 w_push;
  logic                 w_err;
  logic                 w_drop;
  logic                 w_empty;
  logic [PAIR_W-1:0]    w_head;
  logic [DEPTH_LOG2:0]  w_level;

  // Hold-state register, held left sample and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_state <= HOLD_EMPTY;
      r_hold_data  <= {SAMPLE_W{1'b0}};
      r_pair_err   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_hold_state <= w_hold_next;
      r_hold_data  <= w_hold_data_next;
      r_pair_err   <= w_err;
      r_ovf        <= w_drop;
    end
  end

  // Pairing decisions for the current cycle.
  always_comb begin
    w_hold_next      = r_hold_state;
    w_hold_data_next = r_hold_data;
    w_push           = 1'b0;
    w_err            = 1'b0;
    if (!locked_i) begin
      // Losing lock abandons a half pair silently.
      w_hold_next = HOLD_EMPTY;
    end else if (ack_i) begin
      case (lrck_i)
        LRCK_LEFT: begin
          w_hold_next      = HOLD_LEFT;
          w_hold_data_next = data_i;
          w_err            = (r_hold_state == HOLD_LEFT);
        end
        LRCK_RIGHT: begin
          if (r_hold_state == HOLD_LEFT) begin
            w_push      = 1'b1;
            w_hold_next = HOLD_EMPTY;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_hold_next = r_hold_state;
        end
      endcase
    end else begin
      w_hold_next = r_hold_state;
    end
  end

  spdif_pair_fifo #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (pack_pair(r_hold_data, data_i)),
    .i_pop   (ready_i),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign left_o     = pair_left(w_head);
  assign right_o    = pair_right(w_head);
  assign valid_o    = ~w_empty;
  assign level_o    = w_level;
  assign pair_err_o = r_pair_err;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_spdif_sample_pairer.sv
// Directed self-checking bench for spdif_sample_pairer (DEPTH=4).
module tb_spdif_sample_pairer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_i;
  logic        ack_i;
  logic        lrck_i;
  logic        locked_i;
  logic [23:0] left_o;
  logic [23:0] right_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  level_o;
  logic        pair_err_o;
  logic        ovf_o;

  int n_assert = 0;
  int n_fail   = 0;

  spdif_sample_pairer #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .ack_i      (ack_i),
    .lrck_i     (lrck_i),
    .locked_i   (locked_i),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .pair_err_o (pair_err_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic lr, input logic [23:0] d);
    ack_i  = 1'b1;
    lrck_i = lr;
    data_i = d;
    tick();
    ack_i  = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [23:0] l, input logic [23:0] r);
    chk({tag, "_valid"}, valid_o, 1'b1);
    chk({tag, "_left"}, left_o, l);
    chk({tag, "_right"}, right_o, r);
  endtask

  initial begin
    rst_n    = 1'b0;
    data_i   = 24'h0;
    ack_i    = 1'b0;
    lrck_i   = 1'b0;
    locked_i = 1'b1;
    ready_i  = 1'b0;
    tick();
    tick();
    chk("rst_level", level_o, 3'd0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_err", pair_err_o, 1'b0);
    chk("rst_ovf", ovf_o, 1'b0);
    chk("rst_left", left_o, 24'h0);
    chk("rst_right", right_o, 24'h0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: basic pair, ready high, 1-cycle latency then pop
    ready_i = 1'b1;
    send(1'b0, 24'h123456);
    chk("s1_no_valid_after_L", valid_o, 1'b0);
    send(1'b1, 24'hABCDEF);
    chk_head("s1_head", 24'h123456, 24'hABCDEF);
    chk("s1_level1", level_o, 3'd1);
    tick();
    chk("s1_level0", level_o, 3'd0);
    chk("s1_valid0", valid_o, 1'b0);
    ready_i = 1'b0;

    // Scenario 2: double left overwrites the held sample
    send(1'b0, 24'h000001);
    chk("s2_err_first_L", pair_err_o, 1'b0);
    send(1'b0, 24'h000002);
    chk("s2_err_second_L", pair_err_o, 1'b1);
    send(1'b1, 24'h000003);
    chk("s2_err_cleared", pair_err_o, 1'b0);
    chk("s2_level", level_o, 3'd1);
    chk_head("s2_head", 24'h000002, 24'h000003);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("s2_drained", level_o, 3'd0);

    // Scenario 3: fill to DEPTH, fifth pair overflows
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 24'h000100 + 24'(i));
      send(1'b1, 24'h000200 + 24'(i));
      if (i == 4) begin
        chk("s3_level_full", level_o, 3'd4);
        chk("s3_no_ovf_4th", ovf_o, 1'b0);
      end
    end
    chk("s3_ovf_5th", ovf_o, 1'b1);
    chk("s3_level_after_ovf", level_o, 3'd4);
    chk_head("s3_head", 24'h000101, 24'h000201);
    tick();
    chk("s3_ovf_one_cycle", ovf_o, 1'b0);

    // Scenario 4: push while full with a simultaneous pop
    send(1'b0, 24'h000106);
    ready_i = 1'b1;
    send(1'b1, 24'h000206);
    ready_i = 1'b0;
    chk("s4_no_ovf", ovf_o, 1'b0);
    chk("s4_level", level_o, 3'd4);
    chk_head("s4_head_p2", 24'h000102, 24'h000202);
    ready_i = 1'b1;
    tick();
    chk_head("s4_head_p3", 24'h000103, 24'h000203);
    tick();
    chk_head("s4_head_p4", 24'h000104, 24'h000204);
    tick();
    chk_head("s4_head_p6", 24'h000106, 24'h000206);
    tick();
    ready_i = 1'b0;
    chk("s4_empty", valid_o, 1'b0);
    chk("s4_level0", level_o, 3'd0);

    // Scenario 5: lock loss clears the held left without an error pulse
    send(1'b0, 24'hAAAAAA);
    locked_i = 1'b0;
    tick();
    chk("s5_no_err_on_unlock", pair_err_o, 1'b0);
    locked_i = 1'b1;
    send(1'b1, 24'hBBBBBB);
    chk("s5_err_orphan_R", pair_err_o, 1'b1);
    chk("s5_no_push", level_o, 3'd0);
    tick();
    // ack without lock is ignored: a later right sample is still orphaned
    locked_i = 1'b0;
    send(1'b0, 24'hCCCCCC);
    chk("s5_unlocked_ack_no_err", pair_err_o, 1'b0);
    locked_i = 1'b1;
    send(1'b1, 24'hDDDDDD);
    chk("s5_unlocked_L_ignored", pair_err_o, 1'b1);
    chk("s5_level_still0", level_o, 3'd0);
    tick();

    // Scenario 6: contents survive lock loss, then async reset mid-operation
    for (int i = 1; i <= 4; i++) begin
      send(1'b0, 24'h000300 + 24'(i));
      send(1'b1, 24'h000400 + 24'(i));
    end
    locked_i = 1'b0;
    tick();
    chk("s6_retained", level_o, 3'd4);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("s6_drain_unlocked", level_o, 3'd3);
    chk_head("s6_head_unlocked", 24'h000302, 24'h000402);
    locked_i = 1'b0;
    tick();
    locked_i = 1'b1;
    send(1'b0, 24'h0000EE);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_async_level", level_o, 3'd0);
    chk("s6_async_valid", valid_o, 1'b0);
    chk("s6_async_err", pair_err_o, 1'b0);
    chk("s6_async_ovf", ovf_o, 1'b0);
    chk("s6_async_left", left_o, 24'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b1, 24'h0000FF);
    chk("s6_hold_discarded", pair_err_o, 1'b1);
    chk("s6_no_push_after_rst", level_o, 3'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
